// File: rtl/core_define.sv
// Shared load-response definitions: RISC-V load funct3 codes, access
// lengths, the response state type and the beat-count helper.
package core_define;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_DONE = 2'd3
    } rsp_state_t;

    // A load needs a second word when its last byte falls past byte 3.
    function automatic logic needs_two_beats(input logic [1:0] off,
                                             input logic [2:0] len);
        return ({2'b00, off} + {1'b0, len}) > 4'd4;
    endfunction

endpackage

// File: rtl/core_ma_lsu_load_extend.sv
// Combinational load realignment: shifts the two-word window down to the
// addressed byte, keeps 1/2/4 bytes and sign- or zero-extends them.
module core_ma_lsu_load_extend
    import core_define::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  len,
    input  logic [2:0]  op_type,
    output logic [31:0] result,
    output logic        illegal
);

    logic [31:0] word;
    logic        len_ok;
    logic        type_ok;
    logic        sext;

    // Realign, mask by length and extend; illegal encodings come out zero-extended.
    always_comb begin
        word    = 32'(data >> {off, 3'b000});
        len_ok  = (len == LEN_B) || (len == LEN_H) || (len == LEN_W);
        type_ok = (op_type == LB) || (op_type == LH) || (op_type == LW) ||
                  (op_type == LBU) || (op_type == LHU);
        illegal = !(len_ok && type_ok);
        sext    = len_ok && type_ok && !op_type[2];
        result  = word;
        case (len)
            LEN_B:   result = {{24{word[7] & sext}}, word[7:0]};
            LEN_H:   result = {{16{word[15] & sext}}, word[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/core_ma_lsu_read_data_merge.sv
// MA-stage load response: collects one or two in-order Avalon read beats,
// merges and extends them, and holds the result on the mw handshake.
// A watchdog aborts a load whose beats never arrive.
module core_ma_lsu_read_data_merge
    import core_define::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic [2:0]  mem_op_type,
    input  logic [2:0]  mem_op_data_len,
    input  logic        mem_op_cmd_send_done,
    input  logic [31:0] avl_m0_read_data,
    input  logic        avl_m0_read_data_valid,
    input  logic        mw_ready,
    output logic [31:0] load_data,
    output logic        load_data_valid,
    output logic        load_err,
    output logic        rsp_busy
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    rsp_state_t  state;
    logic [1:0]  off_q;
    logic [2:0]  len_q;
    logic [2:0]  type_q;
    logic        two_q;
    logic [31:0] beat0_q;
    logic [CW-1:0] cnt;

    logic [63:0] ext_data;
    logic [31:0] ext_result;
    logic        ext_illegal;
    logic        timeout_hit;
    logic        unused_ok;

    // Only the byte offset matters; cmd_send_done is informational.
    assign unused_ok = ^{mem_addr[31:2], mem_op_cmd_send_done};

    // The final beat is the upper word in W1; a single-beat load pads with zero.
    assign ext_data = (state == ST_W1) ? {avl_m0_read_data, beat0_q}
                                       : {32'h0, avl_m0_read_data};

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == TO_LAST);
    assign rsp_busy    = (state != ST_IDLE);

    core_ma_lsu_load_extend u_extend (
        .data    (ext_data),
        .off     (off_q),
        .len     (len_q),
        .op_type (type_q),
        .result  (ext_result),
        .illegal (ext_illegal)
    );

    // Response FSM with registered result, sticky error and wait watchdog.
    always_ff @(posedge clk) begin
        if (rest) begin
            state           <= ST_IDLE;
            off_q           <= 2'd0;
            len_q           <= 3'd0;
            type_q          <= 3'd0;
            two_q           <= 1'b0;
            beat0_q         <= 32'h0;
            cnt             <= '0;
            load_data       <= 32'h0;
            load_data_valid <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (avl_m0_read_data_valid) begin
                        load_err <= 1'b1;
                    end
                    if (mem_read) begin
                        off_q  <= mem_addr[1:0];
                        len_q  <= mem_op_data_len;
                        type_q <= mem_op_type;
                        two_q  <= needs_two_beats(mem_addr[1:0], mem_op_data_len);
                        cnt    <= '0;
                        state  <= ST_W0;
                    end
                end
                ST_W0, ST_W1: begin
                    if (avl_m0_read_data_valid) begin
                        cnt <= '0;
                        if (state == ST_W0 && two_q) begin
                            beat0_q <= avl_m0_read_data;
                            state   <= ST_W1;
                        end else begin
                            if (state == ST_W0) begin
                                beat0_q <= avl_m0_read_data;
                            end
                            load_data       <= ext_result;
                            load_data_valid <= 1'b1;
                            if (ext_illegal) begin
                                load_err <= 1'b1;
                            end
                            state <= ST_DONE;
                        end
                    end else if (timeout_hit) begin
                        load_err        <= 1'b1;
                        load_data       <= 32'h0;
                        load_data_valid <= 1'b1;
                        cnt             <= '0;
                        state           <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (avl_m0_read_data_valid) begin
                        load_err <= 1'b1;
                    end
                    if (mw_ready) begin
                        load_data_valid <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ma_lsu_read_data_merge.sv
// Directed bench for the load-response merge stage.
module tb_core_ma_lsu_read_data_merge;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic [31:0] mem_addr = 32'h0;
    logic        mem_read = 1'b0;
    logic [2:0]  mem_op_type = 3'd0;
    logic [2:0]  mem_op_data_len = 3'd0;
    logic        mem_op_cmd_send_done = 1'b0;
    logic [31:0] avl_m0_read_data = 32'h0;
    logic        avl_m0_read_data_valid = 1'b0;
    logic        mw_ready = 1'b0;
    logic [31:0] load_data;
    logic        load_data_valid;
    logic        load_err;
    logic        rsp_busy;

    int errors = 0;
    int checks = 0;

    core_ma_lsu_read_data_merge #(.TIMEOUT_CYCLES(8)) dut (
        .clk                    (clk),
        .rest                   (rest),
        .mem_addr               (mem_addr),
        .mem_read               (mem_read),
        .mem_op_type            (mem_op_type),
        .mem_op_data_len        (mem_op_data_len),
        .mem_op_cmd_send_done   (mem_op_cmd_send_done),
        .avl_m0_read_data       (avl_m0_read_data),
        .avl_m0_read_data_valid (avl_m0_read_data_valid),
        .mw_ready               (mw_ready),
        .load_data              (load_data),
        .load_data_valid        (load_data_valid),
        .load_err               (load_err),
        .rsp_busy               (rsp_busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] addr, input logic [2:0] typ,
                              input logic [2:0] len);
        mem_addr        = addr;
        mem_op_type     = typ;
        mem_op_data_len = len;
        mem_read        = 1'b1;
        tick();
        mem_addr        = 32'hDEAD_BEEF;
        mem_op_type     = 3'd7;
        mem_op_data_len = 3'd7;
    endtask

    task automatic give_beat(input logic [31:0] d);
        avl_m0_read_data       = d;
        avl_m0_read_data_valid = 1'b1;
        tick();
        avl_m0_read_data_valid = 1'b0;
        avl_m0_read_data       = 32'h0;
    endtask

    task automatic handshake();
        mw_ready = 1'b1;
        mem_read = 1'b0;
        tick();
        mw_ready = 1'b0;
    endtask

    task automatic do_reset();
        rest = 1'b1;
        tick();
        rest = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rest = 1'b1;
        tick();
        tick();
        checks++; if (load_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h required %h", load_data, 32'h0); end
        checks++; if (load_data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", load_data_valid); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b required 0", load_err); end
        checks++; if (rsp_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", rsp_busy); end
        rest = 1'b0;
        tick();
    endtask

    task automatic test_lw_aligned();
        start_load(32'h1000, 3'd2, 3'd4);
        checks++; if (rsp_busy !== 1'b1) begin errors++; $display("[TB] FAIL lw_w0_busy: got %b required 1", rsp_busy); end
        mem_op_cmd_send_done = 1'b1;
        avl_m0_read_data       = 32'h89AB_CDEF;
        avl_m0_read_data_valid = 1'b1;
        #1;
        checks++; if (load_data_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw_valid_early: got %b required 0", load_data_valid); end
        tick();
        avl_m0_read_data_valid = 1'b0;
        mem_op_cmd_send_done   = 1'b0;
        checks++; if (load_data_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_valid: got %b required 1", load_data_valid); end
        checks++; if (load_data !== 32'h89AB_CDEF) begin errors++; $display("[TB] FAIL lw_data: got %h required %h", load_data, 32'h89AB_CDEF); end
        tick();
        checks++; if (load_data_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_hold: got %b required 1", load_data_valid); end
        handshake();
        checks++; if (load_data_valid !== 1'b0) begin errors++; $display("[TB] FAIL lw_drop: got %b required 0", load_data_valid); end
        checks++; if (rsp_busy !== 1'b0) begin errors++; $display("[TB] FAIL lw_idle: got %b required 0", rsp_busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL lw_err: got %b required 0", load_err); end
    endtask

    task automatic test_lw_cross();
        start_load(32'h1002, 3'd2, 3'd4);
        give_beat(32'h4433_2211);
        checks++; if (load_data_valid !== 1'b0) begin errors++; $display("[TB] FAIL lwx_w1_valid: got %b required 0", load_data_valid); end
        checks++; if (rsp_busy !== 1'b1) begin errors++; $display("[TB] FAIL lwx_w1_busy: got %b required 1", rsp_busy); end
        give_beat(32'h8877_6655);
        checks++; if (load_data_valid !== 1'b1) begin errors++; $display("[TB] FAIL lwx_valid: got %b required 1", load_data_valid); end
        checks++; if (load_data !== 32'h6655_4433) begin errors++; $display("[TB] FAIL lwx_data: got %h required %h", load_data, 32'h6655_4433); end
        handshake();
    endtask

    task automatic test_lh_cross();
        logic [2:0]  typs [2] = '{3'd1, 3'd5};
        logic [31:0] exps [2] = '{32'hFFFF_EEAA, 32'h0000_EEAA};
        for (int i = 0; i < 2; i++) begin
            start_load(32'h1003, typs[i], 3'd2);
            give_beat(32'hAABB_CCDD);
            give_beat(32'h1122_33EE);
            checks++; if (load_data !== exps[i]) begin errors++; $display("[TB] FAIL lh_data[%0d]: got %h required %h", i, load_data, exps[i]); end
            handshake();
        end
    endtask

    task automatic test_lb_hold();
        logic [2:0]  typs [2] = '{3'd0, 3'd4};
        logic [31:0] exps [2] = '{32'hFFFF_FFF5, 32'h0000_00F5};
        for (int i = 0; i < 2; i++) begin
            start_load(32'h1001, typs[i], 3'd1);
            give_beat(32'h0000_F500);
            checks++; if (load_data !== exps[i]) begin errors++; $display("[TB] FAIL lb_data[%0d]: got %h required %h", i, load_data, exps[i]); end
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++; if (load_data_valid !== 1'b1 || load_data !== exps[i]) begin errors++; $display("[TB] FAIL lb_hold[%0d/%0d]: got %b/%h required 1/%h", i, c, load_data_valid, load_data, exps[i]); end
            end
            handshake();
        end
    endtask

    task automatic test_unexpected_beat();
        give_beat(32'hCAFE_F00D);
        checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL unexp_err: got %b required 1", load_err); end
        checks++; if (rsp_busy !== 1'b0 || load_data_valid !== 1'b0) begin errors++; $display("[TB] FAIL unexp_state: got busy=%b valid=%b required 0/0", rsp_busy, load_data_valid); end
        start_load(32'h2000, 3'd2, 3'd4);
        give_beat(32'h1234_5678);
        checks++; if (load_data !== 32'h1234_5678 || load_data_valid !== 1'b1) begin errors++; $display("[TB] FAIL unexp_next: got %h/%b required %h/1", load_data, load_data_valid, 32'h1234_5678); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL unexp_sticky: got %b required 1", load_err); end
        handshake();
    endtask

    task automatic test_timeout();
        do_reset();
        start_load(32'h3000, 3'd2, 3'd4);
        for (int c = 0; c < 7; c++) tick();
        checks++; if (load_data_valid !== 1'b0 || rsp_busy !== 1'b1) begin errors++; $display("[TB] FAIL to_early: got valid=%b busy=%b required 0/1", load_data_valid, rsp_busy); end
        tick();
        checks++; if (load_data_valid !== 1'b1) begin errors++; $display("[TB] FAIL to_valid: got %b required 1", load_data_valid); end
        checks++; if (load_data !== 32'h0) begin errors++; $display("[TB] FAIL to_data: got %h required %h", load_data, 32'h0); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got %b required 1", load_err); end
        handshake();
    endtask

    task automatic test_reset_in_w1();
        do_reset();
        start_load(32'h1000, 3'd2, 3'd4);
        give_beat(32'h89AB_CDEF);
        handshake();
        start_load(32'h1002, 3'd2, 3'd4);
        give_beat(32'h4433_2211);
        rest = 1'b1;
        tick();
        rest = 1'b0;
        checks++; if (load_data !== 32'h0) begin errors++; $display("[TB] FAIL rstw1_data: got %h required %h", load_data, 32'h0); end
        checks++; if (load_data_valid !== 1'b0 || load_err !== 1'b0 || rsp_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstw1_flags: got valid=%b err=%b busy=%b required 0/0/0", load_data_valid, load_err, rsp_busy); end
        mem_read = 1'b0;
        give_beat(32'h8877_6655);
        checks++; if (load_err !== 1'b1 || rsp_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstw1_orphan: got err=%b busy=%b required 1/0", load_err, rsp_busy); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_lw_aligned();
        test_lw_cross();
        test_lh_cross();
        test_lb_hold();
        test_unexpected_beat();
        test_timeout();
        test_reset_in_w1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_ma_lsu_read_data_merge.md
Name: core_ma_lsu_read_data_merge

Overview:
- Load-response stage directly downstream of the LSU address generator in the memory-access (MA) stage.
- The address generator issues one or two aligned 32-bit Avalon reads per load; one read if the load fits in a word, two if it crosses a word boundary.
- This block collects the in-order read beats, merges and realigns them, and applies byte/half/word sign or zero extension.
- It presents the load result to the MA→WB (mw) handshake and raises a timeout error if beats never arrive.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed in a WAIT state without a beat before abort; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rest  in  1  reset: synchronous, active-high
- mem_addr  in  32  load byte address; only [1:0] is used
- mem_read  in  1  load op present in MA (held until mw handshake)
- mem_op_type  in  3  RISC-V load funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5
- mem_op_data_len  in  3  access length in bytes: 1, 2 or 4
- mem_op_cmd_send_done  in  1  from the address generator: all read commands accepted
- avl_m0_read_data  in  32  Avalon read data
- avl_m0_read_data_valid  in  1  Avalon read beat valid (in order, latency ≥1)
- mw_ready  in  1  WB stage accepts the result
- load_data  out  32  merged, extended load result
- load_data_valid  out  1  load_data valid; held until mw_ready
- load_err  out  1  sticky error flag
- rsp_busy  out  1  load in flight (W0/W1/DONE)

Behaviour:
- State machine: IDLE, W0, W1, DONE.
- Reset: state=IDLE, load_data=0, load_data_valid=0, load_err=0, beat0 register=0, timeout counter=0.
- Beat count: two_beats = ({1'b0,mem_addr[1:0]} + mem_op_data_len) > 4.
- IDLE → W0 when mem_read=1.
  - Latch off=mem_addr[1:0], len, type and two_beats into registers. Later changes on these inputs are ignored until IDLE.
- W0 → on beat valid: store beat0.
  - If two_beats, go to W1.
  - Otherwise compute the result and go to DONE.
- W1 → on beat valid: compute the result from {beat, beat0} and go to DONE.
- Result is registered: load_data_valid rises the cycle after the final beat arrives.
- Result computation:
  - Form the 64-bit word {beat1, beat0}; beat1=0 for a single-beat load.
  - Shift right by off*8 and take bits [31:0].
  - len=1: keep [7:0]; len=2: keep [15:0]; len=4: keep all 32 bits.
  - type[2]=0: sign-extend from the top kept bit; type[2]=1: zero-extend.
  - An illegal len or type produces a zero-extended word and sets load_err.
- DONE: load_data_valid=1 and load_data stable while mw_ready=0.
  - On mw_ready=1: go to IDLE and drop load_data_valid the next cycle.
  - A new load can enter W0 no earlier than the cycle after DONE exits, i.e. IDLE is visited for at least one cycle.
- Unexpected beat: a beat arriving in IDLE or DONE is discarded and sets load_err. State is unaffected.
- mem_op_cmd_send_done: informational only. A beat may arrive in the same cycle as cmd_send_done and is accepted.
- Timeout (when TIMEOUT_CYCLES>0):
  - The counter runs in W0/W1 and resets to 0 on every beat and on state entry.
  - When it reaches TIMEOUT_CYCLES-1 with no beat: set load_err, go to DONE with load_data=0, load_data_valid=1.
- load_err: sticky; cleared only by rest.
- rest asserted mid-operation returns all state to reset values next edge. Beats still outstanding on the bus afterwards are treated as unexpected beats.
- mem_read=0 in W0/W1 (pipeline flush) is ignored: the block still consumes the beats it is owed.

Decomposition:
- core_define.sv (shared package/includes): load funct3 constants LB/LH/LW/LBU/LHU, length constants LEN_B/LEN_H/LEN_W, and the state enum type.
- One sub-module, core_ma_lsu_load_extend: purely combinational shift, mask and sign/zero extension.
  - Inputs: 64-bit data, off, len, type.
  - Outputs: 32-bit result and an illegal flag.
  - Reusable by a later store-to-load forwarding path.

Test Plan:
- LW, addr 0x1000, beat 0x89ABCDEF → load_data=0x89ABCDEF, load_data_valid the cycle after the beat, one beat consumed.
- LW, addr 0x1002, beats 0x44332211 then 0x88776655 → load_data=0x66554433; state passes through W1.
- LH, addr 0x1003, beats 0xAABBCCDD then 0x112233EE → load_data=0xFFFFEEAA; LHU with the same stimulus → 0x0000EEAA.
- LB then LBU, addr 0x1001, beat 0x0000F500 → 0xFFFFFFF5, then 0x000000F5; in each case DONE is held 3 cycles with mw_ready=0 and load_data stays stable.
- Beat injected in IDLE → ignored, load_err=1 and stays set; next LW completes normally.
- TIMEOUT_CYCLES=8, LW with no beat → after 8 cycles in W0: load_err=1, load_data=0, load_data_valid=1.
  - Separately: rest asserted while in W1 → IDLE and all outputs 0 next cycle.
